// File: rtl/clk_mux_sw_pkg.sv
// Shared types and constants for the clock-mux select sequencer.
package clk_mux_sw_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned REQ_PWR = 0;
  localparam int unsigned REQ_SW  = 1;

  localparam logic SEL_CLK1 = 1'b0;
  localparam logic SEL_CLK2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACK    = 2'd2,
    DWELL  = 2'd3
  } state_t;

endpackage

// File: rtl/clk_mux_sw_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the loser on advance.
module clk_mux_sw_rr_arb
  import clk_mux_sw_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt_c
);

  logic ptr;

  // A lone request wins outright; a tie goes to the pointed-at requester.
  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = '0;
      gnt_c[ptr ? REQ_SW : REQ_PWR] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~gnt_c[REQ_SW];
    end
  end

endmodule

// File: rtl/clk_mux_sw_ctrl.sv
// Sequencer driving the glitch-free clock mux select with settle and dwell timing.
// Optional switch statistics (sw_count, last_gnt) under CLK_MUX_SW_STATS_EN.
module clk_mux_sw_ctrl
  import clk_mux_sw_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned DWELL_CYCLES  = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_sel,
  output logic [NUM_REQ-1:0] ack,
  output logic               sel,
  output logic               busy
`ifdef CLK_MUX_SW_STATS_EN
  ,
  output logic [15:0]        sw_count,
  output logic [0:0]         last_gnt
`endif
);

  localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam int unsigned DWELL_LOAD  = (DWELL_CYCLES == 0) ? 0 : DWELL_CYCLES - 1;
  localparam bit          HAS_DWELL   = (DWELL_CYCLES != 0);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [NUM_REQ-1:0] gnt, gnt_d, ack_d, arb_gnt_c;
  logic               sel_d, busy_d, switched, switched_d;
  logic               grant_c, target_c;

  assign grant_c  = (state == IDLE) && (arb_gnt_c != '0);
  assign target_c = |(arb_gnt_c & req_sel);

  // A requester still seeing its ack is masked so it cannot be re-granted.
  clk_mux_sw_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req & ~ack),
    .advance (grant_c),
    .gnt_c   (arb_gnt_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= SEL_CLK1;
      ack      <= '0;
      busy     <= 1'b0;
      gnt      <= '0;
      switched <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      sel      <= sel_d;
      ack      <= ack_d;
      busy     <= busy_d;
      gnt      <= gnt_d;
      switched <= switched_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant_c) state_d = (target_c == sel) ? ACK : SETTLE;
      SETTLE:  if (cnt == '0) state_d = ACK;
      ACK:     state_d = (switched && HAS_DWELL) ? DWELL : IDLE;
      DWELL:   if (cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; sel only moves on the IDLE->SETTLE edge.
  always_comb begin
    cnt_d      = cnt;
    sel_d      = sel;
    ack_d      = '0;
    gnt_d      = gnt;
    switched_d = switched;
    busy_d     = (state_d == SETTLE) || (state_d == DWELL);
    case (state)
      IDLE: begin
        if (grant_c) begin
          gnt_d      = arb_gnt_c;
          switched_d = (target_c != sel);
          if (target_c != sel) begin
            sel_d = target_c;
            cnt_d = CNT_W'(SETTLE_LOAD);
          end
        end
      end
      SETTLE, DWELL: begin
        if (cnt != '0) cnt_d = cnt - CNT_W'(1);
      end
      ACK: begin
        ack_d = gnt;
        cnt_d = CNT_W'(DWELL_LOAD);
      end
      default: ;
    endcase
  end

`ifdef CLK_MUX_SW_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_count <= '0;
      last_gnt <= '0;
    end else if (grant_c) begin
      last_gnt <= arb_gnt_c[REQ_SW];
      if ((target_c != sel) && (sw_count != 16'hFFFF)) sw_count <= sw_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_mux_sw_ctrl.sv
// Self-checking bench for clk_mux_sw_ctrl against a transaction-timeline reference model.
module tb_clk_mux_sw_ctrl;

  localparam int S = 8;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, req_sel, ack;
  logic       sel, busy;
`ifdef CLK_MUX_SW_STATS_EN
  logic [15:0] sw_count;
  logic [0:0]  last_gnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_mux_sw_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_sel (req_sel),
    .ack     (ack),
    .sel     (sel),
    .busy    (busy)
`ifdef CLK_MUX_SW_STATS_EN
    ,
    .sw_count(sw_count),
    .last_gnt(last_gnt)
`endif
  );

  // Reference model: each grant schedules its future busy/ack cycles on a timeline.
  logic [1:0] ack_q [64];
  logic       busy_q[64];
  logic       m_sel, exp_busy;
  logic [1:0] m_ack_prev, exp_ack, m_inflight;
  int         m_ptr, m_free, m_cyc, m_sw, m_last;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      ack_q[i]  = 2'b00;
      busy_q[i] = 1'b0;
    end
    m_sel = 1'b0; m_ptr = 0; m_free = 0; m_cyc = 0; m_sw = 0; m_last = 0;
    m_ack_prev = 2'b00; exp_ack = 2'b00; exp_busy = 1'b0; m_inflight = 2'b00;
  endfunction

  function automatic void model_edge(input logic [1:0] r, input logic [1:0] rs);
    int n, g;
    logic [1:0] elig;
    m_cyc++;
    n = m_cyc;
    if (n >= m_free) begin
      elig = r & ~m_ack_prev;
      if (elig != 2'b00) begin
        if (elig == 2'b11) g = m_ptr;
        else g = elig[1] ? 1 : 0;
        m_ptr = 1 - g;
        m_last = g;
        m_inflight[g] = 1'b1;
        if (rs[g] == m_sel) begin
          ack_q[(n + 1) % 64][g] = 1'b1;
          m_free = n + 2;
        end else begin
          m_sel = rs[g];
          if (m_sw < 65535) m_sw++;
          for (int k = 0; k < S; k++) busy_q[(n + k) % 64] = 1'b1;
          ack_q[(n + S + 1) % 64][g] = 1'b1;
          for (int k = 1; k <= D; k++) busy_q[(n + S + k) % 64] = 1'b1;
          m_free = n + S + D + 2;
        end
      end
    end
    exp_ack  = ack_q[n % 64];
    exp_busy = busy_q[n % 64];
    ack_q[n % 64]  = 2'b00;
    busy_q[n % 64] = 1'b0;
    m_ack_prev = exp_ack;
    m_inflight = m_inflight & ~exp_ack;
  endfunction

  // One clock: step the model on the edge, then requesters drop req on seeing ack.
  task automatic tick();
    @(posedge clk);
    model_edge(req, req_sel);
    #1;
    for (int i = 0; i < 2; i++) if (exp_ack[i]) req[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; req_sel = 2'b00;
    @(posedge clk);
    #4;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00; req_sel = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sel, busy, ack} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values sel/busy/ack got %b/%b/%b expected 0/0/00", sel, busy, ack);
    end
`ifdef CLK_MUX_SW_STATS_EN
    checks++;
    if (sw_count !== 16'd0 || last_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_stats got sw_count=%0d last_gnt=%b expected 0/0", sw_count, last_gnt);
    end
`endif
    #3;
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
        errors++;
        $display("FAIL reset_idle t=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                 t, sel, busy, ack, m_sel, exp_busy, exp_ack);
      end
    end
  endtask

  task automatic test_switch();
    int ack0_t = -1, fall_t = -1, ack1_t = -1;
    req[0] = 1'b1; req_sel[0] = 1'b1;
    for (int t = 0; t < 70; t++) begin
      tick();
      checks++;
      if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
        errors++;
        $display("FAIL switch t=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                 t, sel, busy, ack, m_sel, exp_busy, exp_ack);
      end
      if (t == 0) begin
        checks++;
        if (sel !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL switch_grant_edge sel/busy got %b/%b expected 1/1", sel, busy);
        end
      end
      if (t == S + D + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL switch_dwell_end busy got %b expected 0", busy);
        end
      end
      if (ack[0] === 1'b1 && ack0_t < 0) begin
        ack0_t = t;
        req[1] = 1'b1; req_sel[1] = 1'b0;
      end
      if (ack0_t >= 0 && sel === 1'b0 && fall_t < 0) fall_t = t;
      if (ack[1] === 1'b1 && ack1_t < 0) ack1_t = t;
    end
    checks++;
    if (ack0_t != S + 1) begin
      errors++;
      $display("FAIL switch_ack_latency got %0d expected %0d", ack0_t, S + 1);
    end
    checks++;
    if (fall_t < 0 || fall_t - ack0_t != D + 1) begin
      errors++;
      $display("FAIL pending_regrant got %0d expected %0d", fall_t - ack0_t, D + 1);
    end
    checks++;
    if (ack1_t < 0 || ack1_t - fall_t != S + 1) begin
      errors++;
      $display("FAIL pending_ack_latency got %0d expected %0d", ack1_t - fall_t, S + 1);
    end
  endtask

  task automatic test_contention();
    logic [1:0] order[$];
    bit reraised = 1'b0;
    do_reset();
    req = 2'b11; req_sel = 2'b01;
    for (int t = 0; t < 100; t++) begin
      tick();
      checks++;
      if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
        errors++;
        $display("FAIL contention t=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                 t, sel, busy, ack, m_sel, exp_busy, exp_ack);
      end
      if (ack !== 2'b00) order.push_back(ack);
      if (ack[0] === 1'b1 && !reraised) begin
        reraised = 1'b1;
        req[0] = 1'b1; req_sel[0] = 1'b1;
      end
    end
    checks++;
    if (order.size() != 3) begin
      errors++;
      $display("FAIL contention_ack_count got %0d expected 3", order.size());
    end else begin
      checks++;
      if (order[0] !== 2'b01 || order[1] !== 2'b10 || order[2] !== 2'b01) begin
        errors++;
        $display("FAIL contention_order got %b,%b,%b expected 01,10,01", order[0], order[1], order[2]);
      end
    end
  endtask

  task automatic test_noop();
    int ack1_t = -1, rise_t = -1;
    do_reset();
    req[1] = 1'b1; req_sel[1] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++;
      if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
        errors++;
        $display("FAIL noop t=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                 t, sel, busy, ack, m_sel, exp_busy, exp_ack);
      end
      if (t <= 2) begin
        checks++;
        if (sel !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL noop_quiet t=%0d sel/busy got %b/%b expected 0/0", t, sel, busy);
        end
      end
      if (ack[1] === 1'b1 && ack1_t < 0) ack1_t = t;
      if (sel === 1'b1 && rise_t < 0) rise_t = t;
      if (ack1_t >= 0 && t == ack1_t + 1) begin
        req[0] = 1'b1; req_sel[0] = 1'b1;
      end
    end
    checks++;
    if (ack1_t != 1) begin
      errors++;
      $display("FAIL noop_latency got %0d expected 1", ack1_t);
    end
    checks++;
    if (ack1_t < 0 || rise_t != ack1_t + 2) begin
      errors++;
      $display("FAIL noop_then_switch got %0d expected %0d", rise_t, ack1_t + 2);
    end
  endtask

  task automatic test_abort();
    int acks = 0, ack_t = -1;
    do_reset();
    req[0] = 1'b1; req_sel[0] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
        errors++;
        $display("FAIL abort_pre t=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                 t, sel, busy, ack, m_sel, exp_busy, exp_ack);
      end
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({sel, busy, ack} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_async sel/busy/ack got %b/%b/%b expected 0/0/00", sel, busy, ack);
    end
    model_reset();
    #2;
    reset = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      checks++;
      if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
        errors++;
        $display("FAIL abort_post t=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                 t, sel, busy, ack, m_sel, exp_busy, exp_ack);
      end
      if (ack[0] === 1'b1) begin
        acks++;
        if (ack_t < 0) ack_t = t;
      end
    end
    checks++;
    if (acks != 1 || ack_t != S + 1) begin
      errors++;
      $display("FAIL abort_regrant got acks=%0d at t=%0d expected 1 at t=%0d", acks, ack_t, S + 1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 600; t++) begin
      tick();
      checks++;
      if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
        errors++;
        $display("FAIL random t=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                 t, sel, busy, ack, m_sel, exp_busy, exp_ack);
      end
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && !m_inflight[i]) begin
          if ($urandom_range(3) == 0) begin
            req[i] = 1'b1;
            req_sel[i] = 1'($urandom);
          end
        end else if (req[i] && m_inflight[i]) begin
          if ($urandom_range(7) == 0) req_sel[i] = ~req_sel[i];
          else if ($urandom_range(15) == 0) req[i] = 1'b0;
        end
      end
    end
`ifdef CLK_MUX_SW_STATS_EN
    checks++;
    if (sw_count !== 16'(m_sw) || last_gnt !== 1'(m_last)) begin
      errors++;
      $display("FAIL random_stats got sw_count=%0d last_gnt=%b expected %0d/%0d",
               sw_count, last_gnt, m_sw, m_last);
    end
`endif
  endtask

`ifdef CLK_MUX_SW_STATS_EN
  task automatic test_stats();
    int idx[5] = '{0, 1, 1, 0, 0};
    logic tgt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int s = 0; s < 5; s++) begin
      int budget = 0;
      req[idx[s]] = 1'b1;
      req_sel[idx[s]] = tgt[s];
      do begin
        tick();
        budget++;
        checks++;
        if ({sel, busy, ack} !== {m_sel, exp_busy, exp_ack}) begin
          errors++;
          $display("FAIL stats_seq s=%0d sel/busy/ack got %b/%b/%b expected %b/%b/%b",
                   s, sel, busy, ack, m_sel, exp_busy, exp_ack);
        end
      end while (!(req == 2'b00 && m_cyc + 1 >= m_free) && budget < 60);
      if (budget >= 60) begin
        errors++;
        $display("FAIL stats_timeout s=%0d got no completion expected within 60 cycles", s);
      end
    end
    checks++;
    if (sw_count !== 16'd3 || last_gnt !== 1'b0) begin
      errors++;
      $display("FAIL stats_count got sw_count=%0d last_gnt=%b expected 3/0", sw_count, last_gnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_switch();
    test_contention();
    test_noop();
    test_abort();
    test_random();
`ifdef CLK_MUX_SW_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
